// File: rtl/cic_pkg.sv
// rtl/cic_pkg.sv - shared types and constants for the CIC decimation controller
package cic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } cic_state_t;

  localparam int CIC_CNT_W     = 8;
  localparam int CIC_DW        = 16;
  localparam int CIC_RATIO_MIN = 2;

endpackage

// File: rtl/cic_decim_counter.sv
// rtl/cic_decim_counter.sv - modulo-ratio sample counter with terminal-count pulse
module cic_decim_counter
  import cic_pkg::*;
#(
  parameter int CNT_W = CIC_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_ratio,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  // ratio is never below 2, so ratio-1 cannot underflow
  assign w_last = (r_cnt == (i_ratio - CNT_W'(1)));
  assign o_tc   = i_en && w_last;

  // count accepted samples, folding back to zero on the last one of each block
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cic_decim_ctrl.sv
// rtl/cic_decim_ctrl.sv - decimation tick sequencing, warm-up discard and output handshake
module cic_decim_ctrl
  import cic_pkg::*;
#(
  parameter int CNT_W  = CIC_CNT_W,
  parameter int DW     = CIC_DW,
  parameter int WARMUP = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] cfg_ratio,
  input  logic             cfg_load,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  output logic             dec_tick,
  input  logic [DW-1:0]    comb_data,
  output logic [DW-1:0]    out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  output logic [1:0]       state
);

  localparam int DISC_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [DISC_W-1:0] DISC_LAST  = DISC_W'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [CNT_W-1:0]  RATIO_MIN  = CNT_W'(CIC_RATIO_MIN);

  cic_state_t       r_state;
  cic_state_t       w_next;
  logic [CNT_W-1:0] r_ratio;
  logic [DISC_W-1:0] r_disc;
  logic             r_dec_tick;
  logic             r_cap;
  logic [DW-1:0]    r_out_data;
  logic             r_out_valid;
  logic             r_overrun;

  logic w_busy;
  logic w_start;
  logic w_cnt_clr;
  logic w_cnt_en;
  logic w_tc;
  logic w_cap;
  logic w_run_cap;
  logic w_drop;
  logic w_load;

  assign w_busy    = (r_state != ST_IDLE);
  // stop beats start, and start is only honoured from idle
  assign w_start   = (r_state == ST_IDLE) && start && !stop;
  assign w_cnt_clr = !w_busy || stop;
  assign w_cnt_en  = w_busy && in_valid;
  // a capture landing in the stop cycle is thrown away
  assign w_cap     = r_cap && w_busy && !stop;
  assign w_run_cap = w_cap && (r_state == ST_RUN);
  assign w_drop    = w_run_cap && r_out_valid && !out_ready;
  assign w_load    = w_run_cap && !w_drop;

  cic_decim_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .i_ratio (r_ratio),
    .o_tc    (w_tc)
  );

  // ratio register, only writable while idle; degenerate ratios clamp to the minimum
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ratio <= RATIO_MIN;
    end else if ((r_state == ST_IDLE) && cfg_load) begin
      r_ratio <= (cfg_ratio < RATIO_MIN) ? RATIO_MIN : cfg_ratio;
    end
  end

  // tick pipeline: tick follows the terminal sample, capture follows the tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dec_tick <= 1'b0;
      r_cap      <= 1'b0;
    end else begin
      r_dec_tick <= w_tc && !stop;
      r_cap      <= r_dec_tick;
    end
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state: warm-up ends on the last discarded comb output
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_next = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
        end
      end
      ST_WARMUP: begin
        if (stop) begin
          w_next = ST_IDLE;
        end else if (w_cap && (r_disc == DISC_LAST)) begin
          w_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // discard counter for start-up transient outputs of the comb
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_disc <= '0;
    end else if (w_start) begin
      r_disc <= '0;
    end else if ((r_state == ST_WARMUP) && w_cap) begin
      r_disc <= r_disc + DISC_W'(1);
    end
  end

  // output holding register with sticky overrun on a dropped settled sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_start) begin
        r_overrun <= 1'b0;
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end
      if (w_load) begin
        r_out_data  <= comb_data;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign dec_tick  = r_dec_tick;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign busy      = w_busy;
  assign overrun   = r_overrun;
  assign state     = r_state;

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// tb/tb_cic_decim_ctrl.sv - self-checking bench for cic_decim_ctrl
module tb_cic_decim_ctrl;

  localparam int CNT_W  = 8;
  localparam int DW     = 16;
  localparam int WARMUP = 2;

  logic             clk;
  logic             reset = 1'b1;
  logic [CNT_W-1:0] cfg_ratio = '0;
  logic             cfg_load = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             in_valid = 1'b0;
  logic             dec_tick;
  logic [DW-1:0]    comb_data = 16'hDEAD;
  logic [DW-1:0]    out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             busy;
  logic             overrun;
  logic [1:0]       state;

  int n_cmp = 0;
  int n_bad = 0;
  bit ready_mode = 1'b0;

  cic_decim_ctrl #(
    .CNT_W  (CNT_W),
    .DW     (DW),
    .WARMUP (WARMUP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_ratio (cfg_ratio),
    .cfg_load  (cfg_load),
    .start     (start),
    .stop      (stop),
    .in_valid  (in_valid),
    .dec_tick  (dec_tick),
    .comb_data (comb_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .overrun   (overrun),
    .state     (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: ticks come from the total sample count since start
  // (every R-th one), captures are numbered since start and the first WARMUP
  // are discarded; the state is derived from how many captures have happened.
  int          m_busy_run;
  int          m_ratio = 2;
  int          m_acc;
  int          m_capn;
  bit          m_tick;
  bit          m_cap;
  bit          m_valid;
  bit          m_ovr;
  logic [15:0] m_data;

  function automatic logic [1:0] exp_state();
    if (m_busy_run == 0) return 2'd0;
    return (m_capn >= WARMUP) ? 2'd2 : 2'd1;
  endfunction

  always @(posedge clk or posedge reset) begin
    bit was_busy, cap_b, v_b, loaded;
    if (reset) begin
      m_busy_run = 0; m_ratio = 2; m_acc = 0; m_capn = 0;
      m_tick = 0; m_cap = 0; m_valid = 0; m_ovr = 0; m_data = '0;
    end else begin
      was_busy = (m_busy_run != 0);
      cap_b    = m_cap;
      v_b      = m_valid;
      loaded   = 0;
      m_cap    = m_tick;
      if (cap_b && was_busy && !stop) begin
        m_capn++;
        if (m_capn > WARMUP) begin
          if (v_b && !out_ready) m_ovr = 1;
          else begin m_data = comb_data; loaded = 1; end
        end
      end
      if (loaded) m_valid = 1;
      else if (v_b && out_ready) m_valid = 0;
      m_tick = 0;
      if (was_busy && !stop && in_valid) begin
        m_acc++;
        if (m_acc % m_ratio == 0) m_tick = 1;
      end
      if (stop) m_busy_run = 0;
      else if (!was_busy && start) begin
        m_busy_run = 1; m_acc = 0; m_capn = 0; m_ovr = 0;
      end
      if (!was_busy && cfg_load) m_ratio = (int'(cfg_ratio) < 2) ? 2 : int'(cfg_ratio);
    end
  end

  // comb datapath stand-in: capture n since start presents n*0x1000, junk otherwise
  always @(posedge clk) begin
    #2;
    comb_data = m_cap ? 16'((m_capn + 1) * 4096) : 16'hDEAD;
    if (ready_mode) out_ready = m_cap;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // every-cycle comparison against the model
  always @(negedge clk) begin
    chk("dec_tick", {31'd0, dec_tick}, {31'd0, m_tick});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("out_data", {16'd0, out_data}, {16'd0, m_data});
    chk("busy", {31'd0, busy}, {31'd0, m_busy_run != 0});
    chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
    chk("state", {30'd0, state}, {30'd0, exp_state()});
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic load_ratio(input logic [CNT_W-1:0] r);
    cfg_ratio = r; cfg_load = 1'b1; step(); cfg_load = 1'b0;
  endtask

  // k = number of edges after the start edge at which out_valid first shows
  task automatic wait_valid(input int bound, output int k, output logic [15:0] d);
    k = 0;
    @(negedge clk);
    while (!out_valid && k < bound) begin @(negedge clk); k++; end
    d = out_data;
    @(posedge clk); #1;
  endtask

  task automatic tick_period(input int bound, output int per);
    int k;
    k = 0;
    @(negedge clk);
    while (!dec_tick && k < bound) begin @(negedge clk); k++; end
    per = 0;
    do begin @(negedge clk); per++; end while (!dec_tick && per < bound);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int k, per, found;
    logic [15:0] d;

    step(2);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    step();

    // R=4: three captures, the first two discarded; first output is 0x3000
    load_ratio(8'd4);
    in_valid = 1'b1; out_ready = 1'b1;
    pulse_start();
    wait_valid(40, k, d);
    chk("t1_latency", k, 32'd14);
    chk("t1_first_data", {16'd0, d}, 32'h3000);
    tick_period(20, per);
    chk("t1_tick_period", per, 32'd4);
    pulse_stop();
    step(3);

    // ratio 1 clamps to 2; cfg_load in RUN is ignored; gaps stretch the period
    load_ratio(8'd1);
    pulse_start();
    tick_period(20, per);
    chk("t2_period_clamped", per, 32'd2);
    step(10);
    load_ratio(8'd9);
    tick_period(20, per);
    chk("t2_period_after_run_load", per, 32'd2);
    for (int i = 0; i < 24; i++) begin
      in_valid = (i % 3) != 0;
      step();
    end
    in_valid = 1'b1;
    pulse_stop();
    step(3);

    // R=2, consumer stalled: second settled capture is dropped
    load_ratio(8'd2);
    out_ready = 1'b0;
    pulse_start();
    step(14);
    @(negedge clk);
    chk("t3_held_data", {16'd0, out_data}, 32'h3000);
    chk("t3_overrun", {31'd0, overrun}, 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    pulse_stop();

    // restart clears overrun; then ready only in capture cycles (coincident handshake)
    pulse_start();
    ready_mode = 1'b1;
    @(negedge clk);
    chk("t3_overrun_cleared", {31'd0, overrun}, 32'd0);
    step(20);
    @(negedge clk);
    chk("t4_valid_kept", {31'd0, out_valid}, 32'd1);
    chk("t4_no_overrun", {31'd0, overrun}, 32'd0);
    chk("t4_latest_data", {16'd0, out_data}, 32'h9000);
    @(posedge clk); #1;
    ready_mode = 1'b0;
    out_ready = 1'b1;
    pulse_stop();
    step(3);

    // stop in a dec_tick cycle with a held sample
    out_ready = 1'b0;
    load_ratio(8'd4);
    pulse_start();
    wait_valid(40, k, d);
    chk("t5_latency", k, 32'd14);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (m_tick) found = 1; else step();
    end
    chk("t5_tick_found", found, 32'd1);
    pulse_stop();
    @(negedge clk);
    chk("t5_state_idle", {30'd0, state}, 32'd0);
    chk("t5_held_valid", {31'd0, out_valid}, 32'd1);
    chk("t5_held_data", {16'd0, out_data}, 32'h3000);
    step(4);
    @(negedge clk);
    chk("t5_still_held", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    @(negedge clk);
    chk("t5_consumed", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    step(2);

    // asynchronous reset mid-RUN with a valid sample held
    load_ratio(8'd2);
    pulse_start();
    step(12);
    reset = 1'b1;
    #2;
    chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_rst_data", {16'd0, out_data}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_overrun", {31'd0, overrun}, 32'd0);
    chk("t6_rst_state", {30'd0, state}, 32'd0);
    chk("t6_rst_tick", {31'd0, dec_tick}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    step();
    load_ratio(8'd2);
    out_ready = 1'b1;
    pulse_start();
    wait_valid(40, k, d);
    chk("t6_latency", k, 32'd8);
    chk("t6_first_data", {16'd0, d}, 32'h3000);
    step(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
